conv3x3_stream_core: RTL
========================

// Module: conv3x3_stream_core
// PURPOSE
//  Parametrised streaming 3x3 convolution engine, successor to the fixed single-channel layer00 datapath.
//  Accepts raster-order pixels of IN_CH packed channels over a valid/ready stream, with no padding.
//  Buffers two rows internally and produces one requantised int8 output channel of (IMG_H-2)x(IMG_W-2) pixels.
//  Instantiated once per output channel inside layer tops.
// PARAMETERS
//  IN_CH   1   input channels summed per output pixel
//  DW      8   signed activation width
//  WW      8   signed weight width
//  BW      16  signed bias width
//  IMG_W   16  frame width in pixels (>=3)
//  IMG_H   16  frame height in rows (>=3)
//  ACC_W   DW+WW+$clog2(9*IN_CH)+1   accumulator width (derived; do not override)
// PORTS
//  clk        in   1            rising-edge clock
//  rstn       in   1            asynchronous active-low reset
//  iStart     in   1            frame start pulse; latches config; ignored unless IDLE
//  iWeight    in   IN_CH*9*WW   weights; channel c, tap k(=3*r+col) at [(c*9+k)*WW +: WW]
//  iBias      in   BW           signed bias, latched on iStart
//  iShift     in   4            requant right-shift, latched on iStart
//  iReluEn    in   1            1 = clamp negatives to 0, latched on iStart
//  iInValid   in   1            input pixel valid
//  iInData    in   IN_CH*DW     packed pixel, channel c at [c*DW +: DW]
//  oInReady   out  1            pixel accepted when iInValid&oInReady
//  oOutValid  out  1            output pixel valid
//  oOutData   out  8            signed int8 result
//  iOutReady  in   1            downstream ready
//  oBusy      out  1            high from iStart accept until oDone
//  oDone      out  1            one-cycle pulse when frame fully drained
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters/pipeline/line buffers cleared, config regs 0.
//  FSM: IDLE -iStart-> RUN -last pixel (row IMG_H-1, col IMG_W-1) accepted-> DRAIN -pipe empty and last output taken-> DONE -> IDLE.
//   DONE lasts 1 cycle and asserts oDone.
//  Config: iWeight/iBias/iShift/iReluEn sampled only in the iStart cycle; held constant for the frame.
//  Pipeline advances when adv = !oOutValid | iOutReady.
//   oInReady = (state==RUN) & adv.
//  Latency: 3 cycles from accept to oOutValid with no stall.
//   S1: shift window and line buffers, tag pixel.
//   S2: IN_CH*9 products plus per-channel sums.
//   S3: total, bias, round, shift, ReLU, saturate.
//  Counters: col wraps IMG_W-1->0 with row++.
//   A pixel is tagged valid iff row>=2 & col>=2.
//   Untagged pixels flow as bubbles and never raise oOutValid.
//   Exactly (IMG_H-2)*(IMG_W-2) outputs per frame.
//  Window: output at (row,col) uses input rows row-2..row and cols col-2..col.
//   Tap k=0 is the top-left pixel (row-2,col-2).
//  Arithmetic:
//   - All signed. Products DW+WW bits; sum ACC_W bits.
//   - Bias sign-extended to ACC_W and added.
//   - If iShift>0, add 1<<(iShift-1) and arithmetic-shift right by iShift.
//   - If iReluEn and value<0, value=0. Saturate to [-128,127].
//  Stall: while oOutValid & !iOutReady, oOutData and all stages hold; no input accepted; no loss, no duplication.
//  Simultaneous events: iStart during RUN/DRAIN/DONE is ignored.
//   iInValid outside RUN is ignored (oInReady=0).
//  Reset mid-frame: immediate return to IDLE with the reset values above; partial frame discarded.
// STRUCTURE
//  conv_pkg: state enum (IDLE,RUN,DRAIN,DONE), ACC_W function, saturate/round helper functions.
//  Sub-module conv_line_buffer: 2 rows x IMG_W entries of IN_CH*DW, with a single write/read pointer.
//   Advances on an accepted pixel and outputs the pixels at (row-1,col) and (row-2,col).
//  Top holds the FSM, counters, window regs, MAC stages and requant stage.
// TESTING
//  T1 IN_CH=1, 4x4, all weights 1, bias 0, shift 0, pixels 1 -> 4 outputs of 9, then oDone 1 cycle.
//  T2 only tap 4 =1, pixels = raster index 0..15 -> outputs 5,6,9,10 in order.
//  T3 pixels 127, weights 127 -> 127; weights -127, ReLU off -> -128; ReLU on -> 0.
//  T4 weights 1, pixels 1, bias 0, shift 2 -> (9+2)>>2 = 2; bias -9, shift 0 -> 0.
//  T5 iOutReady low 10 cycles mid-frame -> oOutData stable, oInReady 0, full sequence matches T2.
//  T6 rstn low at pixel 7, then new frame -> outputs 0 during reset; second frame equals T2 golden.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and arithmetic helpers for the streaming 3x3 convolution core.
//   state_e     : frame-level FSM states
//   acc_width   : accumulator width needed for 9*in_ch signed products
//   round_shift : round-half-up arithmetic right shift
//   sat_int8    : saturate a wide signed value to [-128,127]
package conv_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } state_e;

  function automatic int acc_width(input int dw, input int ww, input int in_ch);
    return dw + ww + $clog2(9 * in_ch) + 1;
  endfunction

  function automatic logic signed [63:0] round_shift(input logic signed [63:0] v,
                                                     input logic [3:0]         sh);
    logic signed [63:0] rnd;
    if (sh == 4'd0) return v;
    rnd = 64'sd1 <<< (sh - 4'd1);
    return (v + rnd) >>> sh;
  endfunction

  function automatic logic signed [7:0] sat_int8(input logic signed [63:0] v);
    if (v > 64'sd127) return 8'sh7f;
    if (v < -64'sd128) return 8'sh80;
    return v[7:0];
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// Two-row line buffer for the 3x3 window.
// Ports:
//   clk, rstn : clock, asynchronous active-low reset
//   i_clr     : rewind the column pointer (frame start)
//   i_adv     : a pixel is accepted this cycle; store it and advance
//   i_data    : accepted pixel (all channels packed)
//   o_row1    : pixel one row above the current column
//   o_row2    : pixel two rows above the current column
module conv_line_buffer #(
  parameter int WIDTH = 8,
  parameter int IMG_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_clr,
  input  logic             i_adv,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_row1,
  output logic [WIDTH-1:0] o_row2
);

  localparam int AW = $clog2(IMG_W);

  logic [WIDTH-1:0] r_mem1 [IMG_W];
  logic [WIDTH-1:0] r_mem2 [IMG_W];
  logic [AW-1:0]    r_ptr;

  // Reads are combinational so the window sees the old rows in the accept cycle.
  assign o_row1 = r_mem1[r_ptr];
  assign o_row2 = r_mem2[r_ptr];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ptr <= '0;
      for (int i = 0; i < IMG_W; i++) begin
        r_mem1[i] <= '0;
        r_mem2[i] <= '0;
      end
    end else if (i_clr) begin
      r_ptr <= '0;
    end else if (i_adv) begin
      // Age the column: row-1 becomes row-2, new pixel becomes row-1.
      r_mem2[r_ptr] <= r_mem1[r_ptr];
      r_mem1[r_ptr] <= i_data;
      r_ptr         <= (r_ptr == AW'(IMG_W - 1)) ? '0 : r_ptr + AW'(1);
    end
  end

endmodule

// File: rtl/conv3x3_stream_core.sv
// Streaming 3x3 convolution producing one requantised int8 output channel.
// Raster-order pixels in (valid/ready), no padding, (IMG_H-2)x(IMG_W-2) results out.
// Ports:
//   clk, rstn            : clock, asynchronous active-low reset
//   iStart               : frame start pulse, latches config when idle
//   iWeight/iBias/iShift/iReluEn : frame configuration
//   iInValid/iInData/oInReady    : input pixel stream
//   oOutValid/oOutData/iOutReady : output stream (signed int8)
//   oBusy, oDone         : frame status
module conv3x3_stream_core
  import conv_pkg::*;
#(
  parameter int IN_CH = 1,
  parameter int DW    = 8,
  parameter int WW    = 8,
  parameter int BW    = 16,
  parameter int IMG_W = 16,
  parameter int IMG_H = 16,
  parameter int ACC_W = acc_width(DW, WW, IN_CH)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  iStart,
  input  logic [IN_CH*9*WW-1:0] iWeight,
  input  logic [BW-1:0]         iBias,
  input  logic [3:0]            iShift,
  input  logic                  iReluEn,
  input  logic                  iInValid,
  input  logic [IN_CH*DW-1:0]   iInData,
  output logic                  oInReady,
  output logic                  oOutValid,
  output logic [7:0]            oOutData,
  input  logic                  iOutReady,
  output logic                  oBusy,
  output logic                  oDone
);

  localparam int PW = IN_CH * DW;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  state_e r_state, w_state_next;

  logic [CW-1:0]            r_col;
  logic [RW-1:0]            r_row;
  logic [IN_CH*9*WW-1:0]    r_cfg_weight;
  logic signed [BW-1:0]     r_cfg_bias;
  logic [3:0]               r_cfg_shift;
  logic                     r_cfg_relu;

  logic [PW-1:0]            r_win [3][3];  // [row-2..row][col-2..col]
  logic                     r_s1_valid, r_s2_valid, r_s3_valid;
  logic signed [ACC_W-1:0]  r_s2_sum [IN_CH];
  logic signed [7:0]        r_out;

  logic                     w_adv, w_accept, w_start, w_last, w_tag;
  logic                     w_last_col, w_last_row;
  logic [PW-1:0]            w_row1, w_row2;
  logic signed [DW+WW-1:0]  w_prod [IN_CH][9];
  logic signed [ACC_W-1:0]  w_csum [IN_CH];
  logic signed [ACC_W:0]    w_total;
  logic signed [63:0]       w_wide, w_rnd, w_relu;
  logic signed [7:0]        w_res;

  // Control
  assign w_adv      = !r_s3_valid | iOutReady;
  assign oInReady   = (r_state == StRun) & w_adv;
  assign w_accept   = iInValid & oInReady;
  assign w_start    = iStart & (r_state == StIdle);
  assign w_last_col = (r_col == CW'(IMG_W - 1));
  assign w_last_row = (r_row == RW'(IMG_H - 1));
  assign w_last     = w_accept & w_last_col & w_last_row;
  assign w_tag      = (r_row >= RW'(2)) & (r_col >= CW'(2));

  assign oBusy      = (r_state == StRun) | (r_state == StDrain);
  assign oDone      = (r_state == StDone);
  assign oOutValid  = r_s3_valid;
  assign oOutData   = r_out;

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_start) w_state_next = StRun;
      StRun:   if (w_last) w_state_next = StDrain;
      // Drained once S1/S2 are empty and S3 is empty or handing off this cycle.
      StDrain: if (!r_s1_valid && !r_s2_valid && w_adv) w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= StIdle;
      r_col        <= '0;
      r_row        <= '0;
      r_cfg_weight <= '0;
      r_cfg_bias   <= '0;
      r_cfg_shift  <= '0;
      r_cfg_relu   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_start) begin
        r_cfg_weight <= iWeight;
        r_cfg_bias   <= iBias;
        r_cfg_shift  <= iShift;
        r_cfg_relu   <= iReluEn;
        r_col        <= '0;
        r_row        <= '0;
      end else if (w_accept) begin
        if (w_last_col) begin
          r_col <= '0;
          r_row <= w_last_row ? '0 : r_row + RW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
      end
    end
  end

  conv_line_buffer #(
    .WIDTH (PW),
    .IMG_W (IMG_W)
  ) u_line_buffer (
    .clk    (clk),
    .rstn   (rstn),
    .i_clr  (w_start),
    .i_adv  (w_accept),
    .i_data (iInData),
    .o_row1 (w_row1),
    .o_row2 (w_row2)
  );

  // S1: window shifts only on accepted pixels, so it stays aligned with r_s1_valid.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          r_win[r][c] <= '0;
        end
      end
    end else if (w_accept) begin
      for (int r = 0; r < 3; r++) begin
        r_win[r][0] <= r_win[r][1];
        r_win[r][1] <= r_win[r][2];
      end
      r_win[0][2] <= w_row2;
      r_win[1][2] <= w_row1;
      r_win[2][2] <= iInData;
    end
  end

  // S2: products and per-channel sums
  for (genvar gc = 0; gc < IN_CH; gc++) begin : g_ch
    for (genvar gk = 0; gk < 9; gk++) begin : g_tap
      assign w_prod[gc][gk] =
          (DW+WW)'($signed(r_win[gk/3][gk%3][gc*DW +: DW])) *
          (DW+WW)'($signed(r_cfg_weight[(gc*9+gk)*WW +: WW]));
    end
  end

  always_comb begin
    for (int c = 0; c < IN_CH; c++) begin
      w_csum[c] = '0;
      for (int k = 0; k < 9; k++) begin
        w_csum[c] = w_csum[c] + ACC_W'(w_prod[c][k]);
      end
    end
  end

  // S3: total + bias, round/shift, ReLU, saturate
  always_comb begin
    w_total = (ACC_W+1)'(r_cfg_bias);
    for (int c = 0; c < IN_CH; c++) begin
      w_total = w_total + (ACC_W+1)'(r_s2_sum[c]);
    end
  end

  assign w_wide = 64'(w_total);
  assign w_rnd  = round_shift(w_wide, r_cfg_shift);
  assign w_relu = (r_cfg_relu && (w_rnd < 64'sd0)) ? 64'sd0 : w_rnd;
  assign w_res  = sat_int8(w_relu);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s3_valid <= 1'b0;
      r_out      <= '0;
      for (int c = 0; c < IN_CH; c++) begin
        r_s2_sum[c] <= '0;
      end
    end else if (w_adv) begin
      // Untagged pixels enter as bubbles and never reach oOutValid.
      r_s1_valid <= w_accept & w_tag;
      r_s2_valid <= r_s1_valid;
      r_s3_valid <= r_s2_valid;
      for (int c = 0; c < IN_CH; c++) begin
        r_s2_sum[c] <= w_csum[c];
      end
      if (r_s2_valid) r_out <= w_res;
    end
  end

endmodule
